nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 152 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add sequencer driving an external combinational 4-bit adder (no carry-in).
// Optional subtraction (in_sub port, in_a - in_b) is enabled by defining SUB_EN.
`timescale 1ns/1ps
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
`ifdef SUB_EN
    input  logic                   in_sub,
`endif
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
`ifdef SUB_EN
    logic            sub_q, sub_d;
`endif

    logic [3:0]      a_nib, b_nib, b_eff;
    logic            ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
`ifdef SUB_EN
        b_eff = sub_q ? ~b_nib : b_nib;
`else
        b_eff = b_nib;
`endif
        // The adder has no carry-in: fold carry into A; F+1 wraps to 0 and the carry moves on via ovf.
        ovf = carry_q && (a_nib == 4'hF);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SUB_EN
        sub_d     = sub_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d    = in_a;
                    b_d    = in_b;
                    idx_d  = '0;
                    sum_d  = '0;
                    cout_d = 1'b0;
`ifdef SUB_EN
                    sub_d   = in_sub;
                    carry_d = in_sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = ovf ? 4'h0 : a_nib + {3'b000, carry_q};
                add_b   = b_eff;
                carry_d = add_cout | ovf;
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*4 +: 4] = add_s;
                    end
                end
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = add_cout | ovf;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4) with a behavioural 4-bit adder model.
`timescale 1ns/1ps
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [16:0] exp_q[$];
    logic [3:0]  seq_a[4];
    logic [3:0]  seq_b[4];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
`ifdef SUB_EN
        .in_sub   (in_sub),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented result against the oldest expectation; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {15'd0, out_cout, out_sum}, 32'hFFFF_FFFF);
            end else begin
                chk("result", {15'd0, out_cout, out_sum}, {15'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input int unsigned stall);
        int unsigned guard = 0;
        logic        eff_sub;
        logic [16:0] expv;
`ifdef SUB_EN
        eff_sub = sub;
`else
        eff_sub = 1'b0;
`endif
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        if (eff_sub) expv = {(a >= b) ? 1'b1 : 1'b0, 16'(a - b)};
        else         expv = {1'b0, a} + {1'b0, b};
        exp_q.push_back(expv);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = eff_sub;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_sub   = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            seq_a[i] = add_a;
            seq_b[i] = add_b;
            chk("run_flags", {30'd0, in_ready, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("valid_latency", {31'd0, out_valid}, 32'd1);
        for (int unsigned s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_to_idle", {22'd0, out_valid, in_ready, add_a, add_b}, {22'd0, 2'b01, 8'h00});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {out_valid, in_ready, out_cout, add_a, add_b, out_sum},
            {3'b010, 8'h00, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {30'd0, in_ready, out_valid}, 32'd2);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        chk("seq_a_1234", {16'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h4432);
        chk("seq_b_0FFF", {16'd0, seq_b[0], seq_b[1], seq_b[2], seq_b[3]}, 32'hFFF0);

        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        chk("seq_a_ovf", {16'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'hF000);

        do_op(16'hBEEF, 16'h1357, 1'b0, 5);

        // Abort during the second RUN cycle; the partial result must never appear.
        in_valid = 1'b1;
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {out_valid, in_ready, out_cout, add_a, add_b, out_sum},
            {3'b010, 8'h00, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_valid_after_abort", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 0);

`ifdef SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 0);
        do_op(16'h0007, 16'h0005, 1'b1, 2);
        do_op(16'h1234, 16'h1234, 1'b1, 0);
`endif

        do_op(16'h0000, 16'h0000, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1);
        for (int n = 0; n < 40; n++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        @(posedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
